roce_stack_request_splitter: RTL and testbench
==============================================

Name: roce_stack_request_splitter

Overview:
- Upstream neighbour of the RoCE request handler. Accepts one RDMA transfer request of arbitrary length (up to 4 GiB-1) and emits a sequence of chunk requests on the handler's s_rdma_req interface.
- Every emitted chunk length is at most MAX_CHUNK, so the 23-bit datamover length field downstream never overflows.
- The last flag marks the final chunk of each request, so the handler performs one address translation per request.

Parameters:
- MAX_CHUNK, 4096: maximum bytes per emitted chunk. Must be a power of two, 64 <= MAX_CHUNK <= 2^22; any other value is an elaboration error.
- LEN_W, 32: width of the incoming request length.

Ports:
- clk_i  in  1  clock
- areset_i  in  1  asynchronous reset, active-high
- s_req_valid_i  in  1  incoming request valid
- s_req_ready_o  out  1  incoming request ready
- s_req_vaddr_i  in  64  start virtual address
- s_req_len_i  in  LEN_W  total length in bytes
- s_req_qpn_i  in  16  queue pair number
- m_rdma_req_valid_o  out  1  chunk valid (to handler s_rdma_req_valid_i)
- m_rdma_req_ready_i  in  1  chunk ready
- m_rdma_req_vaddr_o  out  64  chunk start vaddr
- m_rdma_req_len_o  out  28  chunk length
- m_rdma_req_qpn_o  out  16  QPN (constant across one request)
- m_rdma_req_last_o  out  1  final chunk of this request
- busy_o  out  1  request in progress
- chunk_cnt_o  out  16  chunks emitted for the current request, saturating at 0xFFFF

Behaviour:
- Reset (async, active-high) returns all outputs to these values:
  - state = SP_IDLE, s_req_ready_o = 1, m_rdma_req_valid_o = 0
  - vaddr, len and qpn outputs = 0, last = 0, busy_o = 0, chunk_cnt_o = 0
  - remaining-length and next-vaddr registers = 0
- Reset mid-request drops the request silently; no further chunks are emitted.
- State machine:
  - SP_IDLE:
    - s_req_ready_o = 1, m_rdma_req_valid_o = 0.
    - On s_req_valid_i: latch qpn, then compute the first chunk as c = min(len, MAX_CHUNK).
    - Register vaddr_o = s_req_vaddr_i, len_o = c, last_o = (len <= MAX_CHUNK).
    - rem = len - c, nxt = vaddr + c; chunk_cnt_o is cleared to 0; go to SP_EMIT.
  - SP_EMIT:
    - s_req_ready_o = 0, m_rdma_req_valid_o = 1, busy_o = 1.
    - Outputs stay stable while ready is low.
    - On m_rdma_req_ready_i, chunk_cnt_o increments. Then:
      - If last_o = 1: go to SP_IDLE.
      - Otherwise, load the next chunk c = min(rem, MAX_CHUNK) in the same cycle: vaddr_o = nxt, len_o = c, last_o = (rem <= MAX_CHUNK), rem -= c, nxt += c. Stay in SP_EMIT, so back-to-back chunks flow at one per cycle.
- Latency and throughput:
  - First chunk is valid one cycle after acceptance.
  - An N-chunk request occupies N cycles of the output at full ready.
  - One idle bubble (SP_IDLE) separates consecutive requests.
- Arithmetic:
  - nxt is a 64-bit add that wraps modulo 2^64 without error.
  - rem is LEN_W bits.
  - len_o is zero-extended to 28 bits.
- Zero-length request: one chunk with len_o = 0 and last_o = 1.
- Exact multiple of MAX_CHUNK: no trailing zero-length chunk; last is set on the final full chunk.
- busy_o is high from acceptance until the cycle after the last handshake.

Optional Feature:
- Macro: ROCE_SPLIT_PAGE_ALIGN_EN.
- Defined: each chunk length is min(rem, MAX_CHUNK, 4096 - vaddr[11:0]), so no chunk crosses a 4 KiB page boundary. Unaligned requests may therefore yield one extra chunk.
- Undefined: boundary logic is absent; chunk lengths depend only on rem and MAX_CHUNK.

Test Plan:
- len = 10000, vaddr = 0x1000, MAX_CHUNK = 4096, ready held high:
  - Chunks (0x1000, 4096, 0), (0x2000, 4096, 0), (0x3000, 1808, 1) on consecutive cycles.
  - chunk_cnt_o = 3 at the end, then s_req_ready_o = 1.
- len = 0, qpn = 0x0011: one chunk with len 0, last 1, qpn 0x0011; busy_o falls after the handshake.
- len = 8192, with m_rdma_req_ready_i low for 5 cycles on the second chunk:
  - Outputs hold at (vaddr + 4096, 4096, last 1) for all 5 cycles.
  - Exactly two handshakes occur; no trailing zero-length chunk.
- areset_i pulsed while in SP_EMIT with rem = 8000:
  - m_rdma_req_valid_o = 0 immediately; the next accepted request starts cleanly with chunk_cnt_o = 0.
- With ROCE_SPLIT_PAGE_ALIGN_EN defined, vaddr = 0x0F00, len = 512:
  - Chunks (0x0F00, 256, 0) and (0x1000, 256, 1).
  - Without the macro: a single chunk (0x0F00, 512, 1).

Source files
------------

// File: rtl/roce_stack_request_splitter.sv
// roce_stack_request_splitter
// Splits one RDMA transfer request of arbitrary length into a train of chunk
// requests no longer than MAX_CHUNK bytes, with last marking the final chunk.
// Optional macro ROCE_SPLIT_PAGE_ALIGN_EN additionally clips every chunk at
// the next 4 KiB page boundary of its start address.
module roce_stack_request_splitter #(
  parameter int MAX_CHUNK = 4096,
  parameter int LEN_W     = 32
) (
  input  logic             clk_i,
  input  logic             areset_i,
  input  logic             s_req_valid_i,
  output logic             s_req_ready_o,
  input  logic [63:0]      s_req_vaddr_i,
  input  logic [LEN_W-1:0] s_req_len_i,
  input  logic [15:0]      s_req_qpn_i,
  output logic             m_rdma_req_valid_o,
  input  logic             m_rdma_req_ready_i,
  output logic [63:0]      m_rdma_req_vaddr_o,
  output logic [27:0]      m_rdma_req_len_o,
  output logic [15:0]      m_rdma_req_qpn_o,
  output logic             m_rdma_req_last_o,
  output logic             busy_o,
  output logic [15:0]      chunk_cnt_o
);

  // Working width for length compares: wide enough for both the request
  // length and the largest legal chunk (2^22 needs 23 bits).
  localparam int EW = (LEN_W > 23) ? LEN_W : 23;

  if (((MAX_CHUNK & (MAX_CHUNK - 1)) != 0) || (MAX_CHUNK < 64) || (MAX_CHUNK > (1 << 22))) begin : g_bad_max_chunk
    $error("MAX_CHUNK must be a power of two in [64, 2^22]");
  end

  typedef enum logic {SP_IDLE = 1'b0, SP_EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [63:0]      vaddr_q, vaddr_d;
  logic [27:0]      len_q, len_d;
  logic [15:0]      qpn_q, qpn_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [63:0]      nxt_q, nxt_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [63:0]      cur_va;
  logic [LEN_W-1:0] cur_rem;
  logic [EW-1:0]    rem_ext;
  logic [EW-1:0]    lim;
  logic [EW-1:0]    chunk;
  logic             chunk_last;

  // Saturating chunk counter increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Source of the chunk being computed: the fresh request in idle, the
  // running remainder/address while emitting.
  always_comb begin
    cur_va  = (state_q == SP_IDLE) ? s_req_vaddr_i : nxt_q;
    cur_rem = (state_q == SP_IDLE) ? s_req_len_i   : rem_q;
  end

`ifdef ROCE_SPLIT_PAGE_ALIGN_EN
  logic [EW-1:0] page_room;
  // Chunk limit is the smaller of MAX_CHUNK and the bytes left in the page.
  always_comb begin
    page_room = EW'(13'd4096 - {1'b0, cur_va[11:0]});
    lim       = (page_room < EW'(MAX_CHUNK)) ? page_room : EW'(MAX_CHUNK);
  end
`else
  assign lim = EW'(MAX_CHUNK);
`endif

  // Chunk length and whether it consumes the whole remainder.
  always_comb begin
    rem_ext    = EW'(cur_rem);
    chunk      = (rem_ext < lim) ? rem_ext : lim;
    chunk_last = (rem_ext <= lim);
  end

  // Next-state and datapath-load logic.
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    len_d   = len_q;
    qpn_d   = qpn_q;
    last_d  = last_q;
    rem_d   = rem_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    case (state_q)
      SP_IDLE: begin
        if (s_req_valid_i) begin
          qpn_d   = s_req_qpn_i;
          vaddr_d = cur_va;
          len_d   = 28'(chunk);
          last_d  = chunk_last;
          rem_d   = cur_rem - LEN_W'(chunk);
          nxt_d   = cur_va + 64'(chunk);
          cnt_d   = 16'd0;
          state_d = SP_EMIT;
        end
      end
      SP_EMIT: begin
        if (m_rdma_req_ready_i) begin
          cnt_d = sat_inc16(cnt_q);
          if (last_q) begin
            state_d = SP_IDLE;
          end else begin
            vaddr_d = cur_va;
            len_d   = 28'(chunk);
            last_d  = chunk_last;
            rem_d   = cur_rem - LEN_W'(chunk);
            nxt_d   = cur_va + 64'(chunk);
          end
        end
      end
      default: state_d = SP_IDLE;
    endcase
  end

  // State and output registers; reset drops any request in flight.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q <= SP_IDLE;
      vaddr_q <= '0;
      len_q   <= '0;
      qpn_q   <= '0;
      last_q  <= 1'b0;
      rem_q   <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      len_q   <= len_d;
      qpn_q   <= qpn_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_req_ready_o      = (state_q == SP_IDLE);
  assign m_rdma_req_valid_o = (state_q == SP_EMIT);
  assign busy_o             = (state_q == SP_EMIT);
  assign m_rdma_req_vaddr_o = vaddr_q;
  assign m_rdma_req_len_o   = len_q;
  assign m_rdma_req_qpn_o   = qpn_q;
  assign m_rdma_req_last_o  = last_q;
  assign chunk_cnt_o        = cnt_q;

endmodule

// File: tb/tb_roce_stack_request_splitter.sv
// Self-checking bench for roce_stack_request_splitter (MAX_CHUNK = 4096).
module tb_roce_stack_request_splitter;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_vaddr = '0;
  logic [31:0] s_len = '0;
  logic [15:0] s_qpn = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_vaddr;
  logic [27:0] m_len;
  logic [15:0] m_qpn;
  logic        m_last;
  logic        busy;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  roce_stack_request_splitter #(.MAX_CHUNK(4096), .LEN_W(32)) dut (
    .clk_i              (clk),
    .areset_i           (areset),
    .s_req_valid_i      (s_valid),
    .s_req_ready_o      (s_ready),
    .s_req_vaddr_i      (s_vaddr),
    .s_req_len_i        (s_len),
    .s_req_qpn_i        (s_qpn),
    .m_rdma_req_valid_o (m_valid),
    .m_rdma_req_ready_i (m_ready),
    .m_rdma_req_vaddr_o (m_vaddr),
    .m_rdma_req_len_o   (m_len),
    .m_rdma_req_qpn_o   (m_qpn),
    .m_rdma_req_last_o  (m_last),
    .busy_o             (busy),
    .chunk_cnt_o        (cnt)
  );

  typedef struct {
    logic [63:0] va;
    logic [31:0] len;
    logic [15:0] qpn;
    int          n;
    logic [27:0] first_len;
    logic [27:0] last_len;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one request with ready held high and check every chunk cycle by cycle.
  task automatic run_req(input int idx, input vec_t v);
    logic [63:0] exp_va;
    logic [27:0] exp_len;
    @(negedge clk);
    chk($sformatf("v%0d.s_ready", idx), 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_vaddr = v.va;
    s_len   = v.len;
    s_qpn   = v.qpn;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    exp_va = v.va;
    for (int k = 0; k < v.n; k++) begin
      if (k == 0) exp_len = v.first_len;
      else if (k == v.n - 1) exp_len = v.last_len;
      else exp_len = 28'd4096;
      chk($sformatf("v%0d.c%0d.valid", idx, k), 64'(m_valid), 64'd1);
      chk($sformatf("v%0d.c%0d.vaddr", idx, k), m_vaddr, exp_va);
      chk($sformatf("v%0d.c%0d.len", idx, k), 64'(m_len), 64'(exp_len));
      chk($sformatf("v%0d.c%0d.last", idx, k), 64'(m_last), 64'(k == v.n - 1));
      chk($sformatf("v%0d.c%0d.qpn", idx, k), 64'(m_qpn), 64'(v.qpn));
      chk($sformatf("v%0d.c%0d.busy", idx, k), 64'(busy), 64'd1);
      chk($sformatf("v%0d.c%0d.cnt", idx, k), 64'(cnt), 64'(k));
      exp_va = exp_va + 64'(exp_len);
      @(posedge clk);
      @(negedge clk);
    end
    chk($sformatf("v%0d.end.valid", idx), 64'(m_valid), 64'd0);
    chk($sformatf("v%0d.end.busy", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d.end.s_ready", idx), 64'(s_ready), 64'd1);
    chk($sformatf("v%0d.end.cnt", idx), 64'(cnt), 64'(v.n));
  endtask

  initial begin
    tbl[0] = '{64'h1000, 32'd10000, 16'h0001, 3, 28'd4096, 28'd1808};
    tbl[1] = '{64'h0, 32'd0, 16'h0011, 1, 28'd0, 28'd0};
    tbl[2] = '{64'h2000, 32'd4096, 16'h0022, 1, 28'd4096, 28'd4096};
    tbl[3] = '{64'h3000, 32'd4097, 16'h0033, 2, 28'd4096, 28'd1};
    tbl[4] = '{64'h10000, 32'd12288, 16'h0044, 3, 28'd4096, 28'd4096};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_F000, 32'd8192, 16'h0055, 2, 28'd4096, 28'd4096};
`ifdef ROCE_SPLIT_PAGE_ALIGN_EN
    tbl[6] = '{64'h0F00, 32'd512, 16'h0066, 2, 28'd256, 28'd256};
`else
    tbl[6] = '{64'h0F00, 32'd512, 16'h0066, 1, 28'd512, 28'd512};
`endif
    tbl[7] = '{64'h5000, 32'd1, 16'hBEEF, 1, 28'd1, 28'd1};

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst.s_ready", 64'(s_ready), 64'd1);
    chk("rst.valid", 64'(m_valid), 64'd0);
    chk("rst.vaddr", m_vaddr, 64'd0);
    chk("rst.len", 64'(m_len), 64'd0);
    chk("rst.qpn", 64'(m_qpn), 64'd0);
    chk("rst.last", 64'(m_last), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.cnt", 64'(cnt), 64'd0);
    areset = 1'b0;

    for (int i = 0; i < 8; i++) run_req(i, tbl[i]);

    // Backpressure on the second chunk of an exact two-chunk request.
    @(negedge clk);
    s_valid = 1'b1; s_vaddr = 64'h4000; s_len = 32'd8192; s_qpn = 16'h0077;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp.c0.vaddr", m_vaddr, 64'h4000);
    chk("bp.c0.last", 64'(m_last), 64'd0);
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.hold%0d.valid", k), 64'(m_valid), 64'd1);
      chk($sformatf("bp.hold%0d.vaddr", k), m_vaddr, 64'h5000);
      chk($sformatf("bp.hold%0d.len", k), 64'(m_len), 64'd4096);
      chk($sformatf("bp.hold%0d.last", k), 64'(m_last), 64'd1);
      chk($sformatf("bp.hold%0d.cnt", k), 64'(cnt), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.end.valid", 64'(m_valid), 64'd0);
    chk("bp.end.cnt", 64'(cnt), 64'd2);
    chk("bp.end.busy", 64'(busy), 64'd0);

    // Reset while emitting with 8000 bytes still outstanding.
    m_ready = 1'b0;
    s_valid = 1'b1; s_vaddr = 64'h8000; s_len = 32'd12096; s_qpn = 16'h0099;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("mr.pre.valid", 64'(m_valid), 64'd1);
    chk("mr.pre.len", 64'(m_len), 64'd4096);
    areset = 1'b1;
    #1;
    chk("mr.valid", 64'(m_valid), 64'd0);
    chk("mr.s_ready", 64'(s_ready), 64'd1);
    chk("mr.len", 64'(m_len), 64'd0);
    chk("mr.busy", 64'(busy), 64'd0);
    @(negedge clk);
    areset = 1'b0;
    m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mr.quiet.valid", 64'(m_valid), 64'd0);
    end
    run_req(8, '{64'h7000, 32'd100, 16'h00AA, 1, 28'd100, 28'd100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
